// File: rtl/mc_controller_fsm.sv
// Multicycle ARM control unit: main FSM, instruction decoder and condition logic
// merged into one block, with an optional multi-cycle MUL execute phase.
module mc_controller_fsm #(
    parameter bit          HAS_MUL     = 1'b1,
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned ALUCTRL_W   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:4]          Instr,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           RegSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Busy
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_MULEX, S_ALUWB, S_BRANCH
    } state_e;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b000);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b001);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b010);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3'b011);
    localparam logic [ALUCTRL_W-1:0] ALU_MUL = ALUCTRL_W'(3'b100);
    localparam logic [3:0]           MUL_LOAD = 4'(MUL_LATENCY - 1);

    state_e     r_state;
    logic [3:0] r_flags;
    logic       r_cond_ex;
    logic [3:0] r_mul_cnt;

    logic [1:0]           w_op;
    logic [3:0]           w_cmd;
    logic [3:0]           w_cond;
    logic                 w_s;
    logic                 w_rd15;
    logic                 w_is_mul_pat;
    logic                 w_is_cmp;
    logic                 w_arith;
    logic                 w_cmd_ok;
    logic                 w_cond_ex;
    logic [ALUCTRL_W-1:0] w_alu_dp;
    logic                 w_unused;

    assign w_op         = Instr[27:26];
    assign w_cmd        = Instr[24:21];
    assign w_s          = Instr[20];
    assign w_cond       = Instr[31:28];
    assign w_rd15       = &Instr[15:12];
    assign w_is_mul_pat = (w_op == 2'b00) && (w_cmd == 4'b0000) && (Instr[7:4] == 4'b1001);
    assign w_is_cmp     = (w_cmd == 4'b1010);
    assign w_arith      = (w_cmd == 4'b0100) || (w_cmd == 4'b0010) || w_is_cmp;
    assign w_cmd_ok     = w_arith || (w_cmd == 4'b0000) || (w_cmd == 4'b1100);
    assign w_unused     = ^{Instr[19:16], Instr[11:8]};

    // Condition check against the flags stored by earlier flag-setting instructions.
    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ex = r_flags[2];
            4'b0001: w_cond_ex = !r_flags[2];
            4'b0010: w_cond_ex = r_flags[1];
            4'b0011: w_cond_ex = !r_flags[1];
            4'b0100: w_cond_ex = r_flags[3];
            4'b0101: w_cond_ex = !r_flags[3];
            4'b0110: w_cond_ex = r_flags[0];
            4'b0111: w_cond_ex = !r_flags[0];
            4'b1000: w_cond_ex = r_flags[1] && !r_flags[2];
            4'b1001: w_cond_ex = !r_flags[1] || r_flags[2];
            4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
            4'b1100: w_cond_ex = !r_flags[2] && (r_flags[3] == r_flags[0]);
            4'b1101: w_cond_ex = r_flags[2] || (r_flags[3] != r_flags[0]);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_dp = ALU_ADD;
        case (w_cmd)
            4'b0010, 4'b1010: w_alu_dp = ALU_SUB;
            4'b0000:          w_alu_dp = ALU_AND;
            4'b1100:          w_alu_dp = ALU_ORR;
            default:          w_alu_dp = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register update in step at the edge.
        if (reset) begin
            r_state   <= S_FETCH;
            r_flags   <= 4'b0000;
            r_cond_ex <= 1'b0;
            r_mul_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_cond_ex <= w_cond_ex;
                    case (w_op)
                        2'b01: r_state <= S_MEMADR;
                        2'b10: r_state <= S_BRANCH;
                        2'b00: begin
                            if (w_is_mul_pat) begin
                                r_state   <= HAS_MUL ? S_MULEX : S_FETCH;
                                r_mul_cnt <= MUL_LOAD;
                            end else if (!w_cmd_ok) begin
                                r_state <= S_FETCH;
                            end else begin
                                r_state <= Instr[25] ? S_EXECI : S_EXECR;
                            end
                        end
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= Instr[20] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXECR, S_EXECI: begin
                    if (r_cond_ex && (w_s || w_is_cmp)) begin
                        r_flags[3:2] <= ALUFlags[3:2];
                        if (w_arith) r_flags[1:0] <= ALUFlags[1:0];
                    end
                    r_state <= w_is_cmp ? S_FETCH : S_ALUWB;
                end
                S_MULEX: begin
                    // MUL only defines N and Z; C and V carry over.
                    if (r_mul_cnt == 4'd0) begin
                        if (r_cond_ex && w_s) r_flags[3:2] <= ALUFlags[3:2];
                        r_state <= S_ALUWB;
                    end else begin
                        r_mul_cnt <= r_mul_cnt - 4'd1;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = r_cond_ex;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = r_cond_ex;
            end
            S_EXECR: ALUControl = w_alu_dp;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_dp;
            end
            S_MULEX: ALUControl = ALU_MUL;
            S_ALUWB: begin
                RegWrite = r_cond_ex;
                PCWrite  = r_cond_ex && w_rd15;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = r_cond_ex;
            end
            default: ;
        endcase
        // Write enables are held off combinationally while reset is asserted.
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
        end
    end

    assign Busy   = (r_state != S_FETCH);
    assign RegSrc = {w_op == 2'b01, w_op == 2'b10};
    assign ImmSrc = w_op;

endmodule

// File: tb/tb_mc_controller_fsm.sv
// Directed bench for mc_controller_fsm: per-cycle expected control words are queued
// for each instruction and popped against the DUT outputs every cycle.
module tb_mc_controller_fsm;

    logic        clk = 1'b0;
    logic        reset_a, reset_b;
    logic [31:4] instr_a, instr_b;
    logic [3:0]  alu_flags;

    logic       pcw_a, memw_a, regw_a, irw_a, adr_a, busy_a;
    logic [1:0] regsrc_a, srca_a, srcb_a, res_a, imm_a;
    logic [2:0] aluc_a;
    logic       pcw_b, memw_b, regw_b, irw_b, adr_b, busy_b;
    logic [1:0] regsrc_b, srca_b, srcb_b, res_b, imm_b;
    logic [2:0] aluc_b;

    logic [18:0] obs_a, obs_b;
    assign obs_a = {pcw_a, memw_a, regw_a, irw_a, adr_a, srca_a, srcb_a, res_a, aluc_a, busy_a, regsrc_a, imm_a};
    assign obs_b = {pcw_b, memw_b, regw_b, irw_b, adr_b, srca_b, srcb_b, res_b, aluc_b, busy_b, regsrc_b, imm_b};

    mc_controller_fsm #(.HAS_MUL(1'b1), .MUL_LATENCY(3), .ALUCTRL_W(3)) dut_a (
        .clk(clk), .reset(reset_a), .Instr(instr_a), .ALUFlags(alu_flags),
        .PCWrite(pcw_a), .MemWrite(memw_a), .RegWrite(regw_a), .IRWrite(irw_a),
        .AdrSrc(adr_a), .RegSrc(regsrc_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a),
        .ResultSrc(res_a), .ImmSrc(imm_a), .ALUControl(aluc_a), .Busy(busy_a)
    );

    mc_controller_fsm #(.HAS_MUL(1'b0), .MUL_LATENCY(3), .ALUCTRL_W(3)) dut_b (
        .clk(clk), .reset(reset_b), .Instr(instr_b), .ALUFlags(alu_flags),
        .PCWrite(pcw_b), .MemWrite(memw_b), .RegWrite(regw_b), .IRWrite(irw_b),
        .AdrSrc(adr_b), .RegSrc(regsrc_b), .ALUSrcA(srca_b), .ALUSrcB(srcb_b),
        .ResultSrc(res_b), .ImmSrc(imm_b), .ALUControl(aluc_b), .Busy(busy_b)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
        T_EXECR, T_EXECI, T_MULEX, T_ALUWB, T_BRANCH
    } tst_e;

    typedef struct {
        string       tag;
        logic [18:0] vec;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] cur_ins;
    logic        cur_rst;
    string       cur_name;

    // Expected control word for one cycle, straight from the per-state output table.
    function automatic logic [18:0] exp_vec(tst_e s, logic [2:0] alu, logic c, logic [31:0] ins, logic rst);
        logic       pcw, memw, regw, irw, adr, busy;
        logic [1:0] sa, sb, rs, op;
        logic [2:0] ac;
        pcw = 0; memw = 0; regw = 0; irw = 0; adr = 0;
        sa = 2'b00; sb = 2'b00; rs = 2'b00; ac = 3'b000;
        busy = (s != T_FETCH);
        case (s)
            T_FETCH:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; irw = 1; pcw = 1; end
            T_DECODE: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            T_MEMADR: sb = 2'b01;
            T_MEMRD:  adr = 1;
            T_MEMWB:  begin rs = 2'b01; regw = c; end
            T_MEMWR:  begin adr = 1; memw = c; end
            T_EXECR:  ac = alu;
            T_EXECI:  begin sb = 2'b01; ac = alu; end
            T_MULEX:  ac = 3'b100;
            T_ALUWB:  begin regw = c; pcw = c && (ins[15:12] == 4'hF); end
            T_BRANCH: begin sb = 2'b01; rs = 2'b10; pcw = c; end
            default: ;
        endcase
        if (rst) begin pcw = 0; memw = 0; regw = 0; irw = 0; end
        op = ins[27:26];
        return {pcw, memw, regw, irw, adr, sa, sb, rs, ac, busy, op == 2'b01, op == 2'b10, op};
    endfunction

    function automatic logic [31:0] dp(logic [3:0] cond, logic i, logic [3:0] cmd, logic s,
                                       logic [3:0] rn, logic [3:0] rd, logic [11:0] src2);
        return {cond, 2'b00, i, cmd, s, rn, rd, src2};
    endfunction

    function automatic logic [31:0] mem(logic [3:0] cond, logic l, logic [3:0] rn, logic [3:0] rd, logic [11:0] imm);
        return {cond, 2'b01, 5'b01100, l, rn, rd, imm};
    endfunction

    function automatic logic [31:0] br(logic [3:0] cond, logic [23:0] imm);
        return {cond, 2'b10, 2'b10, imm};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    endtask

    task automatic push(input tst_e s, input logic [2:0] alu, input logic c);
        exp_t e;
        e.tag = {cur_name, ".", s.name()};
        e.vec = exp_vec(s, alu, c, cur_ins, cur_rst);
        sb_q.push_back(e);
    endtask

    task automatic slot(input bit sel);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $error("FAIL scoreboard: observed 'h%0h required (queue empty)", sel ? obs_b : obs_a);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, sel ? 32'(obs_b) : 32'(obs_a), 32'(e.vec));
        end
    endtask

    // Starts just after a falling edge; each cycle is compared 1ns later, ends on a falling edge.
    task automatic run(input bit sel, input logic [31:0] ins, input logic [3:0] af, input int n);
        if (sel) instr_b = ins[31:4];
        else     instr_a = ins[31:4];
        alu_flags = af;
        for (int i = 0; i < n; i++) begin
            #1;
            slot(sel);
            @(negedge clk);
        end
    endtask

    localparam logic [31:0] NOP11 = {4'hE, 2'b11, 26'd0};
    localparam logic [31:0] MULS  = {4'hE, 7'b0, 1'b1, 4'd1, 4'd0, 4'd3, 4'b1001, 4'd2};

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        instr_a = NOP11[31:4]; instr_b = NOP11[31:4];
        alu_flags = 4'h0;

        cur_name = "reset"; cur_ins = NOP11; cur_rst = 1'b1;
        push(T_FETCH, 3'b000, 1'b0); push(T_FETCH, 3'b000, 1'b0);
        @(negedge clk);
        run(0, NOP11, 4'h0, 2);
        check_eq("reset.flags", 32'(dut_a.r_flags), 32'h0);
        reset_a = 1'b0; cur_rst = 1'b0;

        cur_name = "adds"; cur_ins = dp(4'hE, 1'b0, 4'b0100, 1'b1, 4'd2, 4'd1, 12'h003);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0);
        push(T_EXECR, 3'b000, 1'b0); push(T_ALUWB, 3'b000, 1'b1);
        run(0, cur_ins, 4'b0110, 4);
        check_eq("adds.flags", 32'(dut_a.r_flags), 32'b0110);

        cur_name = "strne"; cur_ins = mem(4'h1, 1'b0, 4'd1, 4'd4, 12'h004);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0);
        push(T_MEMADR, 3'b000, 1'b0); push(T_MEMWR, 3'b000, 1'b0);
        run(0, cur_ins, 4'b0000, 4);
        check_eq("strne.flags", 32'(dut_a.r_flags), 32'b0110);

        cur_name = "cmp_nos"; cur_ins = dp(4'hE, 1'b0, 4'b1010, 1'b0, 4'd1, 4'd0, 12'h002);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0); push(T_EXECR, 3'b001, 1'b0);
        run(0, cur_ins, 4'b0100, 3);
        check_eq("cmp_nos.flags", 32'(dut_a.r_flags), 32'b0100);

        cur_name = "beq_taken"; cur_ins = br(4'h0, 24'h000002);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0); push(T_BRANCH, 3'b000, 1'b1);
        run(0, cur_ins, 4'b0000, 3);

        cur_name = "cmps"; cur_ins = dp(4'hE, 1'b0, 4'b1010, 1'b1, 4'd1, 4'd0, 12'h002);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0); push(T_EXECR, 3'b001, 1'b0);
        run(0, cur_ins, 4'b0000, 3);
        check_eq("cmps.flags", 32'(dut_a.r_flags), 32'b0000);

        cur_name = "beq_not"; cur_ins = br(4'h0, 24'h000002);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0); push(T_BRANCH, 3'b000, 1'b0);
        run(0, cur_ins, 4'b0000, 3);

        cur_name = "ldr"; cur_ins = mem(4'hE, 1'b1, 4'd1, 4'd4, 12'h004);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0); push(T_MEMADR, 3'b000, 1'b0);
        push(T_MEMRD, 3'b000, 1'b0); push(T_MEMWB, 3'b000, 1'b1);
        run(0, cur_ins, 4'b1111, 5);

        cur_name = "str"; cur_ins = mem(4'hE, 1'b0, 4'd1, 4'd4, 12'h008);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0);
        push(T_MEMADR, 3'b000, 1'b0); push(T_MEMWR, 3'b000, 1'b1);
        run(0, cur_ins, 4'b1111, 4);

        cur_name = "cmp_c1"; cur_ins = dp(4'hE, 1'b0, 4'b1010, 1'b1, 4'd1, 4'd0, 12'h002);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0); push(T_EXECR, 3'b001, 1'b0);
        run(0, cur_ins, 4'b0001, 3);
        check_eq("cmp_c1.flags", 32'(dut_a.r_flags), 32'b0001);

        cur_name = "muls"; cur_ins = MULS;
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) push(T_MULEX, 3'b000, 1'b0);
        push(T_ALUWB, 3'b000, 1'b1);
        run(0, cur_ins, 4'b1011, 6);
        check_eq("muls.flags", 32'(dut_a.r_flags), 32'b1001);

        cur_name = "ands"; cur_ins = dp(4'hE, 1'b0, 4'b0000, 1'b1, 4'd2, 4'd1, 12'h003);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0);
        push(T_EXECR, 3'b010, 1'b0); push(T_ALUWB, 3'b000, 1'b1);
        run(0, cur_ins, 4'b0111, 4);
        check_eq("ands.flags", 32'(dut_a.r_flags), 32'b0101);

        cur_name = "orr_imm"; cur_ins = dp(4'hE, 1'b1, 4'b1100, 1'b0, 4'd2, 4'd1, 12'h001);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0);
        push(T_EXECI, 3'b011, 1'b0); push(T_ALUWB, 3'b000, 1'b1);
        run(0, cur_ins, 4'b1010, 4);
        check_eq("orr_imm.flags", 32'(dut_a.r_flags), 32'b0101);

        cur_name = "eor_nop"; cur_ins = dp(4'hE, 1'b0, 4'b0001, 1'b1, 4'd2, 4'd1, 12'h003);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0);
        run(0, cur_ins, 4'b1111, 2);

        cur_name = "add_pc"; cur_ins = dp(4'hE, 1'b1, 4'b0100, 1'b0, 4'd0, 4'hF, 12'h008);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0);
        push(T_EXECI, 3'b000, 1'b0); push(T_ALUWB, 3'b000, 1'b1);
        run(0, cur_ins, 4'b0000, 4);

        cur_name = "op11"; cur_ins = NOP11;
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0);
        run(0, cur_ins, 4'b0000, 2);

        cur_name = "addsne"; cur_ins = dp(4'h1, 1'b0, 4'b0100, 1'b1, 4'd2, 4'd1, 12'h003);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0);
        push(T_EXECR, 3'b000, 1'b0); push(T_ALUWB, 3'b000, 1'b0);
        run(0, cur_ins, 4'b1111, 4);
        check_eq("addsne.flags", 32'(dut_a.r_flags), 32'b0101);

        cur_name = "mul_rst"; cur_ins = MULS;
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0); push(T_MULEX, 3'b000, 1'b0);
        run(0, cur_ins, 4'b1111, 3);
        reset_a = 1'b1; cur_rst = 1'b1;
        push(T_MULEX, 3'b000, 1'b0); push(T_FETCH, 3'b000, 1'b0);
        run(0, cur_ins, 4'b1111, 2);
        reset_a = 1'b0; cur_rst = 1'b0;
        check_eq("mul_rst.flags", 32'(dut_a.r_flags), 32'h0);

        cur_name = "add_after_rst"; cur_ins = dp(4'hE, 1'b0, 4'b0100, 1'b0, 4'd6, 4'd5, 12'h007);
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0);
        push(T_EXECR, 3'b000, 1'b0); push(T_ALUWB, 3'b000, 1'b1);
        run(0, cur_ins, 4'b1111, 4);

        instr_a = NOP11[31:4];
        reset_b = 1'b0;
        cur_name = "nomul"; cur_ins = MULS;
        push(T_FETCH, 3'b000, 1'b0); push(T_DECODE, 3'b000, 1'b0); push(T_FETCH, 3'b000, 1'b0);
        run(1, cur_ins, 4'b1011, 3);
        check_eq("nomul.flags", 32'(dut_b.r_flags), 32'h0);

        check_eq("scoreboard.empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
